// File: rtl/pla_b12_pkg.sv
// Shared definitions for the PLA result FIFO: vector widths and the stored entry layout.
package pla_b12_pkg;

    localparam int PLA_X_W   = 15;
    localparam int PLA_Z_W   = 9;
    localparam int PLA_SEQ_W = 8;

    // One stored FIFO entry: sequence stamp, PLA input vector, PLA result vector
    typedef struct packed {
        logic [PLA_SEQ_W-1:0] seq;
        logic [PLA_X_W-1:0]   x;
        logic [PLA_Z_W-1:0]   z;
    } pla_entry_t;

endpackage

// File: rtl/pla_b12_fifo_mem.sv
// Entry storage for the result FIFO: one synchronous write port, one asynchronous read port.
// Contents are data only and are deliberately not reset.
module pla_b12_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted, stored push
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pla_b12_result_fifo.sv
// Sequence-stamping FIFO for PLA {x, z} result pairs.
// Optional macro PLA_B12_CHANGE_FILTER_EN: drop accepted samples whose z repeats the
// last stored z (handshake still completes, seq counter does not advance).
module pla_b12_result_fifo
    import pla_b12_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [14:0]                in_x,
    input  logic [8:0]                 in_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [14:0]                out_x,
    output logic [8:0]                 out_z,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = SEQ_W + PLA_X_W + PLA_Z_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [SEQ_W-1:0]   seq_q;
    logic               push_acc;
    logic               pop_acc;
    logic               store;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake flags come from registered occupancy only; reset masks both sides
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push_acc  = in_valid && in_ready && !rst;
    assign pop_acc   = out_valid && out_ready && !rst;

`ifdef PLA_B12_CHANGE_FILTER_EN
    logic               have_last_q;
    logic [PLA_Z_W-1:0] last_z_q;

    assign store = push_acc && !(have_last_q && (in_z == last_z_q));

    // Track the z of the most recently stored entry; the flag makes the first sample after reset always store
    always_ff @(posedge clk) begin
        if (rst) begin
            have_last_q <= 1'b0;
        end else if (store) begin
            have_last_q <= 1'b1;
            last_z_q    <= in_z;
        end
    end
`else
    assign store = push_acc;
`endif

    // Occupancy, pointers and sequence counter; pointers and seq wrap naturally at their widths
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            seq_q   <= '0;
        end else begin
            if (store) begin
                wptr_q <= wptr_q + PTR_W'(1);
                seq_q  <= seq_q + SEQ_W'(1);
            end
            if (pop_acc) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (store && !pop_acc) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!store && pop_acc) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    pla_b12_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wptr_q),
        .wdata ({seq_q, in_x, in_z}),
        .raddr (rptr_q),
        .rdata (rd_entry)
    );

    assign out_seq = rd_entry[ENTRY_W-1 -: SEQ_W];
    assign out_x   = rd_entry[PLA_Z_W +: PLA_X_W];
    assign out_z   = rd_entry[PLA_Z_W-1:0];
    assign count   = count_q;

endmodule

// File: tb/tb_pla_b12_result_fifo.sv
// Scoreboard bench for pla_b12_result_fifo: a queue-based reference model is updated from
// the driven stimulus at each rising edge; a monitor compares the DUT on the falling edge.
module tb_pla_b12_result_fifo;
    import pla_b12_pkg::*;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_x;
    logic [8:0]  in_z;
    logic        out_valid;
    logic        out_ready;
    logic [SEQ_W-1:0] out_seq;
    logic [14:0] out_x;
    logic [8:0]  out_z;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // Reference model state
    pla_entry_t exp_q[$];
    int         mseq = 0;
    bit         have_last = 1'b0;
    logic [8:0] last_z = '0;

    always #5 clk = ~clk;

    pla_b12_result_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_seq   (out_seq),
        .out_x     (out_x),
        .out_z     (out_z),
        .count     (count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, seq as plain modular arithmetic
    always @(posedge clk) begin : model
        bit pop, push, keep;
        pla_entry_t e;
        if (rst) begin
            exp_q.delete();
            mseq      = 0;
            have_last = 1'b0;
        end else begin
            pop  = (exp_q.size() != 0) && out_ready;
            push = in_valid && (exp_q.size() != DEPTH);
            if (pop) exp_q.delete(0);
            if (push) begin
                keep = 1'b1;
`ifdef PLA_B12_CHANGE_FILTER_EN
                keep = !(have_last && (in_z == last_z));
`endif
                if (keep) begin
                    e.seq = 8'(mseq);
                    e.x   = in_x;
                    e.z   = in_z;
                    exp_q.push_back(e);
                    mseq      = (mseq + 1) % 256;
                    have_last = 1'b1;
                    last_z    = in_z;
                end
            end
        end
    end

    // Monitor: occupancy, handshake flags and the presented head entry
    always @(negedge clk) begin
        if (started) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_seq", 32'(out_seq), 32'(exp_q[0].seq));
                chk("out_x", 32'(out_x), 32'(exp_q[0].x));
                chk("out_z", 32'(out_z), 32'(exp_q[0].z));
            end
        end
    end

    task automatic drive(input logic iv, input logic [14:0] x, input logic [8:0] z,
                         input logic ordy, input logic r = 1'b0);
        in_valid  = iv;
        in_x      = x;
        in_z      = z;
        out_ready = ordy;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(1'b0, 15'h0, 9'h0, ordy);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_z = '0;
        @(posedge clk);
        #1;
        started = 1'b1;
        drive(1'b1, 15'h7FFF, 9'h1FF, 1'b1, 1'b1);   // reset ignores handshakes

        // Single push into empty FIFO, visible next cycle with seq 0
        drive(1'b1, 15'h0000, 9'h1B8, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Fill to full, 5th offered sample refused, then drain in order
        for (int i = 0; i < 5; i++) drive(1'b1, 15'(i + 16'h100), 9'(i + 2), 1'b0);
        idle(5, 1'b1);

        // Full FIFO with simultaneous push offer and pop: pop only
        for (int i = 0; i < 4; i++) drive(1'b1, 15'(i + 16'h200), 9'(i + 20), 1'b0);
        drive(1'b1, 15'h1234, 9'h055, 1'b1);
        idle(5, 1'b1);

        // Reset with three entries held, during an offered transfer
        for (int i = 0; i < 3; i++) drive(1'b1, 15'(i + 16'h300), 9'(i + 40), 1'b0);
        drive(1'b1, 15'h4321, 9'h0AA, 1'b1, 1'b1);
        drive(1'b1, 15'h0001, 9'h0AB, 1'b0);
        idle(2, 1'b1);

        // Streaming well past 256 pushes to wrap the sequence stamp
        for (int i = 0; i < 300; i++) drive(1'b1, 15'(i), 9'(i), 1'b1);
        idle(4, 1'b1);

        // Repeated z followed by a new z
        drive(1'b0, 15'h0, 9'h0, 1'b0, 1'b1);
        drive(1'b1, 15'h0010, 9'h1B8, 1'b0);
        drive(1'b1, 15'h0011, 9'h1B8, 1'b0);
        drive(1'b1, 15'h0012, 9'h0FF, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Randomized traffic with occasional resets and repeated z values
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] z;
            z = ($urandom_range(0, 2) == 0) ? in_z : 9'($urandom_range(0, 511));
            drive(1'($urandom_range(0, 3) != 0), 15'($urandom), z,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
        end
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
